// File: rtl/sd_pkg.sv
// sd_pkg: shared FSM state, command and error encodings for sd_spi_init
package sd_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_DUMMY, S_SEND, S_RESP_WAIT, S_RESP_SHIFT, S_CHECK, S_GAP, S_DONE, S_ERROR
    } state_t;
    typedef enum logic [2:0] {C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD58} cmd_t;
    localparam logic [5:0]  IDX_CMD0    = 6'd0;
    localparam logic [5:0]  IDX_CMD8    = 6'd8;
    localparam logic [5:0]  IDX_CMD55   = 6'd55;
    localparam logic [5:0]  IDX_ACMD41  = 6'd41;
    localparam logic [5:0]  IDX_CMD58   = 6'd58;
    localparam logic [31:0] ARG_ZERO    = 32'h0000_0000;
    localparam logic [31:0] ARG_CMD8    = 32'h0000_01AA;
    localparam logic [31:0] ARG_ACMD41  = 32'h4000_0000;
    localparam logic [11:0] CMD8_ECHO   = 12'h1AA;
    localparam logic [7:0]  CRC_CMD0    = 8'h95;
    localparam logic [7:0]  CRC_CMD8    = 8'h87;
    localparam logic [7:0]  CRC_OTHER   = 8'h01;
    localparam logic [2:0]  ERR_NONE    = 3'd0;
    localparam logic [2:0]  ERR_CMD0    = 3'd1;
    localparam logic [2:0]  ERR_CMD8    = 3'd2;
    localparam logic [2:0]  ERR_ACMD41  = 3'd3;
    localparam logic [2:0]  ERR_CMD58   = 3'd4;
    localparam logic [2:0]  ERR_TIMEOUT = 3'd5;

    // First 40 frame bits: {start 0, tx 1, index, argument}
    function automatic logic [39:0] cmd_head(cmd_t c);
        logic [5:0]  idx;
        logic [31:0] arg;
        idx = (c == C_CMD0) ? IDX_CMD0 : (c == C_CMD8) ? IDX_CMD8 :
              (c == C_CMD55) ? IDX_CMD55 : (c == C_ACMD41) ? IDX_ACMD41 : IDX_CMD58;
        arg = (c == C_CMD8) ? ARG_CMD8 : (c == C_ACMD41) ? ARG_ACMD41 : ARG_ZERO;
        return {2'b01, idx, arg};
    endfunction

    function automatic logic [7:0] cmd_crc(cmd_t c);
        return (c == C_CMD0) ? CRC_CMD0 : (c == C_CMD8) ? CRC_CMD8 : CRC_OTHER;
    endfunction

    // CMD8 (R7) and CMD58 (R3) return 40-bit responses, the rest 8-bit R1
    function automatic logic cmd_long(cmd_t c);
        return (c == C_CMD8) || (c == C_CMD58);
    endfunction
endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC-7 (x^7 + x^3 + 1), one bit per clock, MSB first
// Ports: clk, rst_n (async active-low), clr (sync clear), en (shift din), din, crc[6:0]
module sd_crc7 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);
    logic fb;
    assign fb = din ^ crc[6];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) crc <= '0;
        else if (clr) crc <= '0;
        else if (en) crc <= {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
endmodule

// File: rtl/sd_spi_init.sv
// sd_spi_init: SPI-mode SD card initialisation sequencer (CMD0, CMD8, CMD55/ACMD41 loop, CMD58)
// Ports: SCLK clock, reset_n async active-low reset, start kicks the sequence from IDLE/ERROR,
//        MISO card data; CS/MOSI card side; busy/done/error status levels, sdhc = OCR CCS,
//        err_code failure cause (0 none, 1 CMD0, 2 CMD8, 3 ACMD41, 4 CMD58, 5 timeout).
// Build option: define SD_INIT_CRC_EN to compute every CRC7 with sd_crc7 instead of fixed bytes.
module sd_spi_init
    import sd_pkg::*;
#(
    parameter int          DUMMY_CLOCKS     = 80,
    parameter int          RESP_TIMEOUT     = 255,
    parameter logic [15:0] ACMD41_MAX_TRIES = 16'd1000
) (
    input  logic       SCLK,
    input  logic       reset_n,
    input  logic       start,
    input  logic       MISO,
    output logic       CS,
    output logic       MOSI,
    output logic       busy,
    output logic       done,
    output logic       sdhc,
    output logic       error,
    output logic [2:0] err_code
);
    localparam logic [15:0] DUMMY_LAST = 16'(DUMMY_CLOCKS - 1);
    localparam logic [15:0] WAIT_LAST  = 16'(RESP_TIMEOUT - 1);

    state_t      state, state_nx;
    cmd_t        cmd, cmd_nx;
    logic [15:0] cnt, cnt_nx, tries, tries_nx, tries_inc;
    logic [39:0] resp, resp_nx;
    logic        sdhc_nx;
    logic [2:0]  err_nx;
    logic [7:0]  r1, crc_byte;
    logic [47:0] frame;
    logic        tx_bit;

    assign frame  = {cmd_head(cmd), crc_byte};
    assign tx_bit = frame[6'd47 - cnt[5:0]];

`ifdef SD_INIT_CRC_EN
    logic [6:0] crc;
    // Fed the 40 header bits as they go out; holds the result for the last 8 SEND cycles
    sd_crc7 u_crc (
        .clk  (SCLK),
        .rst_n(reset_n),
        .clr  (state != S_SEND),
        .en   (state == S_SEND && cnt < 16'd40),
        .din  (tx_bit),
        .crc  (crc)
    );
    assign crc_byte = {crc, 1'b1};
`else
    assign crc_byte = cmd_crc(cmd);
`endif

    // R1 is the first byte received: top of the 40-bit shift for R3/R7
    assign r1        = cmd_long(cmd) ? resp[39:32] : resp[7:0];
    assign tries_inc = (tries == 16'hFFFF) ? tries : tries + 16'd1;

    assign busy  = !(state inside {S_IDLE, S_DONE, S_ERROR});
    assign CS    = !(state inside {S_SEND, S_RESP_WAIT, S_RESP_SHIFT, S_CHECK, S_GAP});
    assign MOSI  = (state == S_SEND) ? tx_bit : 1'b1;
    assign done  = state == S_DONE;
    assign error = state == S_ERROR;

    always_ff @(posedge SCLK or negedge reset_n)
        if (!reset_n) begin
            state    <= S_IDLE;
            cmd      <= C_CMD0;
            cnt      <= '0;
            tries    <= '0;
            resp     <= '0;
            sdhc     <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_nx;
            cmd      <= cmd_nx;
            cnt      <= cnt_nx;
            tries    <= tries_nx;
            resp     <= resp_nx;
            sdhc     <= sdhc_nx;
            err_code <= err_nx;
        end

    always_comb begin
        state_nx = state;
        cmd_nx   = cmd;
        cnt_nx   = cnt;
        tries_nx = tries;
        resp_nx  = resp;
        sdhc_nx  = sdhc;
        err_nx   = err_code;
        case (state)
            S_IDLE, S_ERROR: if (start) begin
                state_nx = S_DUMMY;
                cmd_nx   = C_CMD0;
                cnt_nx   = '0;
                tries_nx = '0;
                err_nx   = ERR_NONE;
            end
            S_DUMMY: begin
                state_nx = (cnt == DUMMY_LAST) ? S_SEND : S_DUMMY;
                cnt_nx   = (cnt == DUMMY_LAST) ? 16'd0 : cnt + 16'd1;
            end
            S_SEND: begin
                state_nx = (cnt == 16'd47) ? S_RESP_WAIT : S_SEND;
                cnt_nx   = (cnt == 16'd47) ? 16'd0 : cnt + 16'd1;
                resp_nx  = '0;
            end
            S_RESP_WAIT:
                if (!MISO) begin
                    // start bit wins even on the final wait cycle; it is R1 bit 7
                    state_nx = S_RESP_SHIFT;
                    cnt_nx   = 16'd1;
                    resp_nx  = {resp[38:0], MISO};
                end else if (cnt == WAIT_LAST) begin
                    state_nx = S_ERROR;
                    err_nx   = ERR_TIMEOUT;
                end else cnt_nx = cnt + 16'd1;
            S_RESP_SHIFT: begin
                resp_nx  = {resp[38:0], MISO};
                cnt_nx   = cnt + 16'd1;
                state_nx = (cnt == (cmd_long(cmd) ? 16'd39 : 16'd7)) ? S_CHECK : S_RESP_SHIFT;
            end
            S_CHECK: begin
                state_nx = S_GAP;
                cnt_nx   = '0;
                case (cmd)
                    C_CMD0:
                        if (r1 == 8'h01) cmd_nx = C_CMD8;
                        else begin state_nx = S_ERROR; err_nx = ERR_CMD0; end
                    C_CMD8:
                        if (r1 == 8'h01 && resp[11:0] == CMD8_ECHO) cmd_nx = C_CMD55;
                        else begin state_nx = S_ERROR; err_nx = ERR_CMD8; end
                    C_CMD55:
                        if (r1[7:1] == 7'd0) cmd_nx = C_ACMD41;
                        else begin state_nx = S_ERROR; err_nx = ERR_ACMD41; end
                    C_ACMD41:
                        if (r1 == 8'h00) cmd_nx = C_CMD58;
                        else if (r1 == 8'h01 && tries_inc < ACMD41_MAX_TRIES) begin
                            tries_nx = tries_inc;
                            cmd_nx   = C_CMD55;
                        end else begin
                            tries_nx = (r1 == 8'h01) ? tries_inc : tries;
                            state_nx = S_ERROR;
                            err_nx   = ERR_ACMD41;
                        end
                    default:
                        if (r1 == 8'h00) begin state_nx = S_DONE; sdhc_nx = resp[30]; end
                        else begin state_nx = S_ERROR; err_nx = ERR_CMD58; end
                endcase
            end
            S_GAP: begin
                state_nx = (cnt == 16'd7) ? S_SEND : S_GAP;
                cnt_nx   = (cnt == 16'd7) ? 16'd0 : cnt + 16'd1;
            end
            S_DONE: state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_sd_spi_init.sv
// tb_sd_spi_init: scoreboard bench with an SD card model for sd_spi_init
module tb_sd_spi_init;
    localparam int TO = 255;
    localparam logic [47:0] F_CMD0  = 48'h4000_0000_0095;
    localparam logic [47:0] F_CMD8  = 48'h4800_0001_AA87;
    localparam logic [47:0] F_CMD55 = 48'h7700_0000_0001;
    localparam logic [47:0] F_A41   = 48'h6940_0000_0001;
    localparam logic [47:0] F_CMD58 = 48'h7A00_0000_0001;

    logic SCLK = 0, reset_n = 0, start = 0, MISO = 1;
    logic CS, MOSI, busy, done, sdhc, error;
    logic [2:0] err_code;
    int n_chk = 0, n_pass = 0;

    logic [47:0] exp_frame[$];
    logic [47:0] exp_mask[$];
    logic [5:0]  exp_out[$];

    bit silent0 = 0, bad_echo = 0, always1 = 0;
    logic [47:0] rx;
    int rx_bits = 0, frames = 0, acmd_n = 0, wait_cnt = 0, dcnt = 0;
    bit rx_on = 0, counting = 0, fin_q = 0;
    bit tx_q[$];

    sd_spi_init #(.DUMMY_CLOCKS(80), .RESP_TIMEOUT(TO), .ACMD41_MAX_TRIES(16'd4)) dut (
        .SCLK(SCLK), .reset_n(reset_n), .start(start), .MISO(MISO), .CS(CS), .MOSI(MOSI),
        .busy(busy), .done(done), .sdhc(sdhc), .error(error), .err_code(err_code)
    );

    always #5 SCLK = ~SCLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic push_frame(input logic [47:0] f);
        exp_frame.push_back(f);
`ifdef SD_INIT_CRC_EN
        exp_mask.push_back((f[45:40] == 6'd0 || f[45:40] == 6'd8) ? '1 : 48'hFFFF_FFFF_FF01);
`else
        exp_mask.push_back('1);
`endif
    endtask

    task automatic push_seq(input int pairs, input bit with58);
        push_frame(F_CMD0);
        push_frame(F_CMD8);
        for (int i = 0; i < pairs; i++) begin push_frame(F_CMD55); push_frame(F_A41); end
        if (with58) push_frame(F_CMD58);
    endtask

    task automatic card_reply(input logic [47:0] f);
        logic [47:0] em, ef;
        logic [39:0] r;
        int len;
        n_chk++;
        if (exp_frame.size() == 0) $display("FAIL frame: unexpected 0x%012h", f);
        else begin
            em = exp_mask.pop_front();
            ef = exp_frame.pop_front();
            if ((f & em) === (ef & em)) n_pass++;
            else $display("FAIL frame: got 0x%012h expected 0x%012h", f, ef);
        end
        frames++;
        len = 8;
        r = '0;
        case (f[45:40])
            6'd0: begin frames = 1; acmd_n = 0; r[39:32] = 8'h01; end
            6'd8: begin len = 40; r = {8'h01, bad_echo ? 32'h0000_00AA : 32'h0000_01AA}; end
            6'd55: r[39:32] = 8'h01;
            6'd41: begin acmd_n++; r[39:32] = (always1 || acmd_n <= 2) ? 8'h01 : 8'h00; end
            6'd58: begin len = 40; r = {8'h00, 32'hC0FF_8000}; end
            default: len = 0;
        endcase
        if (f[45:40] == 6'd0 && silent0) begin counting = 1; wait_cnt = 0; end
        else if (len > 0) begin
            tx_q.push_back(1'b1);
            for (int i = 39; i >= 40 - len; i--) tx_q.push_back(r[i]);
        end
    endtask

    // Card: samples MOSI and drives MISO on the falling edge
    always @(negedge SCLK) begin
        if (CS) begin
            rx_on = 0; rx_bits = 0; counting = 0; tx_q.delete(); MISO = 1'b1;
        end else begin
            MISO = (tx_q.size() > 0) ? tx_q.pop_front() : 1'b1;
            if (counting) wait_cnt++;
            if (!rx_on && tx_q.size() == 0 && !MOSI) begin rx_on = 1; rx_bits = 0; end
            if (rx_on) begin
                rx = {rx[46:0], MOSI};
                rx_bits++;
                if (rx_bits == 48) begin rx_on = 0; card_reply(rx); end
            end
        end
    end

    // Dummy-clock monitor: CS-high busy cycles before the first frame
    always @(negedge SCLK) begin
        if (busy && CS) dcnt++;
        else begin
            if (dcnt > 0 && !CS) chk("dummy_clocks", dcnt, 80);
            dcnt = 0;
        end
    end

    // Outcome monitor: compares {done,error,err_code,sdhc} when done/error rises
    always @(negedge SCLK) begin
        if ((done || error) && !fin_q) begin
            if (exp_out.size() == 0) begin
                n_chk++;
                $display("FAIL outcome: unexpected done=%0b error=%0b code=%0d", done, error, err_code);
            end else chk("outcome", {done, error, err_code, sdhc}, exp_out.pop_front());
        end
        fin_q = done || error;
    end

    task automatic pulse_start;
        @(negedge SCLK) start = 1;
        @(negedge SCLK) start = 0;
    endtask

    task automatic wait_fin(input string nm);
        int k = 0;
        while (!(done || error) && k < 20000) begin @(negedge SCLK); k++; end
        if (!(done || error)) begin n_chk++; $display("FAIL %s: timeout waiting for done/error", nm); end
        @(negedge SCLK);
    endtask

    task automatic do_reset(input bit check_q);
        if (check_q) chk("queues_drained", exp_frame.size() + exp_out.size(), 0);
        reset_n = 0;
        repeat (2) @(negedge SCLK);
        exp_frame.delete(); exp_mask.delete(); exp_out.delete();
        reset_n = 1;
        @(negedge SCLK);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge SCLK);
        chk("reset_outs", {CS, MOSI, busy, done, error, sdhc, err_code}, 9'b110000000);
        reset_n = 1;
        repeat (3) @(negedge SCLK);
        chk("idle_outs", {CS, MOSI, busy, done, error, sdhc, err_code}, 9'b110000000);

        // Normal card: ACMD41 busy twice, ready on the third
        push_seq(3, 1);
        exp_out.push_back(6'b100001);
        pulse_start;
        wait_fin("normal");
        chk("acmd41_frames", acmd_n, 3);
        pulse_start;
        repeat (10) @(negedge SCLK);
        chk("done_ignores_start", {done, busy, CS, MOSI}, 4'b1011);
        do_reset(1);

        // Silent card after CMD0: timeout
        silent0 = 1;
        push_frame(F_CMD0);
        exp_out.push_back(6'b011010);
        pulse_start;
        wait_fin("timeout");
        chk("timeout_wait_cycles", wait_cnt, TO);
        chk("timeout_cs_mosi_busy", {CS, MOSI, busy}, 3'b110);
        silent0 = 0;
        do_reset(1);

        // Bad CMD8 echo, then restart from ERROR with a good card
        bad_echo = 1;
        push_frame(F_CMD0);
        push_frame(F_CMD8);
        exp_out.push_back(6'b010100);
        pulse_start;
        wait_fin("bad_echo");
        bad_echo = 0;
        push_seq(3, 1);
        exp_out.push_back(6'b100001);
        pulse_start;
        chk("error_cleared", {error, err_code, busy}, 5'b00001);
        wait_fin("restart");
        do_reset(1);

        // ACMD41 never ready: four pairs then code 3
        always1 = 1;
        push_seq(4, 0);
        exp_out.push_back(6'b010110);
        pulse_start;
        wait_fin("acmd41_exhaust");
        chk("acmd41_pairs", acmd_n, 4);
        always1 = 0;
        do_reset(1);

        // Reset in the middle of the CMD8 frame
        push_frame(F_CMD0);
        pulse_start;
        k = 0;
        while (!(frames == 1 && rx_on && rx_bits >= 20) && k < 5000) begin @(negedge SCLK); k++; end
        if (k >= 5000) begin n_chk++; $display("FAIL mid_cmd8: never reached CMD8 frame"); end
        reset_n = 0;
        #1;
        chk("async_reset_outs", {CS, MOSI, busy, done, error}, 5'b11000);
        do_reset(0);
        push_seq(3, 1);
        exp_out.push_back(6'b100001);
        pulse_start;
        wait_fin("after_reset");
        chk("final_queues_drained", exp_frame.size() + exp_out.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
